tempsens_conv_ctrl: RTL and testbench
=====================================

// Module: tempsens_conv_ctrl
//
// PURPOSE
// Conversion sequencer for the tempsenseInst macro. Drives RESET_COUNTERn,
// en and SEL_CONV_TIME, waits for DONE and captures DOUT into a result register.
// Supports single-shot and periodic modes, a conversion timeout and a
// high-temperature alarm. Sits between the TL-UL register adapter (config and
// status) and the sensor macro.
//
// PARAMETERS
// RstCycles  4   cycles sens_rstn_o is held low before each conversion (>=1)
// TimeoutW   24  width of timeout counter / timeout_i
// PeriodW    24  width of periodic-interval counter / period_i
//
// PORTS
// clk_i                 in   1         system clock
// rst_ni                in   1         async reset, active low
// start_i               in   1         single-cycle pulse: start a conversion
// periodic_en_i         in   1         level: restart after each conversion
// period_i              in   PeriodW   idle cycles between periodic conversions
// timeout_i             in   TimeoutW  max cycles in RUN waiting for DONE; 0 = no limit
// sel_conv_time_i       in   4         conversion-time select for the macro
// thresh_hi_i           in   24        alarm threshold on the captured result
// sens_done_i           in   1         DONE from macro (async to clk_i)
// sens_dout_i           in   24        DOUT from macro (stable while DONE=1)
// sens_rstn_o           out  1         RESET_COUNTERn to macro
// sens_en_o             out  1         en to macro
// sens_sel_conv_time_o  out  4         SEL_CONV_TIME to macro
// result_o              out  24        last captured DOUT
// result_valid_o        out  1         1-cycle pulse when result_o updates
// busy_o                out  1         1 while state != IDLE
// timeout_err_o         out  1         sticky; cleared by the next start_i
// alarm_o               out  1         level: last result_o >= thresh_hi_i
//
// BEHAVIOUR
// - Reset: state=IDLE; sens_rstn_o=0, sens_en_o=0, sens_sel_conv_time_o=0,
//   result_o=0, result_valid_o=0, busy_o=0, timeout_err_o=0, alarm_o=0.
// - sens_done_i passes through a 2-flop synchronizer (done_s, reset 0) before use.
// - FSM states and transitions:
//   IDLE: start_i, or periodic_en_i rising edge -> RST. Latch sel_conv_time_i
//     into sens_sel_conv_time_o; clear timeout_err_o.
//   RST: sens_rstn_o=0 for RstCycles cycles -> RUN.
//   RUN: sens_rstn_o=1, sens_en_o=1. Timeout counter counts from 0.
//     done_s=1 -> CAPT.
//     timeout_i!=0 and count==timeout_i-1 -> set timeout_err_o, go to DISARM,
//     no capture.
//   CAPT: one cycle. result_o<=sens_dout_i; result_valid_o=1 this cycle
//     (registered, so visible next cycle); alarm_o<=(sens_dout_i>=thresh_hi_i),
//     unsigned compare. -> DISARM.
//   DISARM: sens_en_o=0 and sens_rstn_o=1; wait for done_s=0.
//     Then: periodic_en_i=1 -> WAIT, else -> IDLE.
//   WAIT: count period_i cycles (period_i=0 -> 0 cycles) -> RST.
//     periodic_en_i=0 -> IDLE immediately.
// - start_i while busy_o=1 is ignored (no queueing).
// - Clearing periodic_en_i mid-conversion lets the current conversion complete,
//   then returns to IDLE.
// - sel_conv_time_i changes take effect only at the next IDLE->RST or WAIT->RST
//   transition.
// - DOUT is sampled only in CAPT, at least 2 cycles after DONE rose. The macro
//   guarantees DOUT stable while DONE=1.
// - Counters saturate; no wrap-around. The timeout counter is cleared on RUN entry.
// - Async reset mid-conversion: macro en/rstn drop to 0 immediately; result is lost.
//
// TESTING
// 1. start_i with DONE model rising 50 cycles after en and DOUT=24'h00ABCD ->
//    sens_rstn_o low 4 cycles; result_o=24'h00ABCD; one result_valid_o pulse;
//    busy_o drops once DONE falls.
// 2. timeout_i=100 and DONE never rises -> timeout_err_o=1 after 100 RUN cycles;
//    result_o unchanged; en=0; state returns to IDLE. Next start_i clears the flag.
// 3. periodic_en_i=1 with period_i=10 -> back-to-back conversions with exactly
//    10 WAIT cycles between DISARM exit and RST entry. Clearing periodic_en_i
//    mid-RUN -> IDLE after the capture.
// 4. thresh_hi_i=24'h001000 with DOUT 24'h000FFF then 24'h001000 ->
//    alarm_o=0, then alarm_o=1.
// 5. start_i pulsed during RUN, and sel_conv_time_i changed during RUN ->
//    no extra conversion; new sel value appears only at the next start.
// 6. rst_ni asserted in RUN -> all outputs at reset values asynchronously;
//    a new start_i after release works normally.

Source files
------------

// File: rtl/tempsens_conv_ctrl.sv
// Conversion sequencer for the tempsenseInst macro: drives RESET_COUNTERn / en /
// SEL_CONV_TIME, waits for a synchronized DONE, captures DOUT and flags alarm and
// timeout conditions. Single-shot and periodic operation.
module tempsens_conv_ctrl #(
    parameter int unsigned RstCycles = 4,
    parameter int unsigned TimeoutW  = 24,
    parameter int unsigned PeriodW   = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                periodic_en_i,
    input  logic [PeriodW-1:0]  period_i,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic [3:0]          sel_conv_time_i,
    input  logic [23:0]         thresh_hi_i,
    input  logic                sens_done_i,
    input  logic [23:0]         sens_dout_i,
    output logic                sens_rstn_o,
    output logic                sens_en_o,
    output logic [3:0]          sens_sel_conv_time_o,
    output logic [23:0]         result_o,
    output logic                result_valid_o,
    output logic                busy_o,
    output logic                timeout_err_o,
    output logic                alarm_o
);

    // One shared counter serves RST, RUN (timeout) and WAIT (period).
    localparam int unsigned CntW = (TimeoutW > PeriodW) ? TimeoutW : PeriodW;
    localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StCapt,
        StDisarm,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic              done_meta, done_s;
    logic              periodic_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   timeout_ext, period_ext;
    logic              start_evt, timeout_hit, period_hit;
    logic [3:0]        sel_q;
    logic [23:0]       result_q;
    logic              valid_q, err_q, alarm_q;

    assign timeout_ext = CntW'(timeout_i);
    assign period_ext  = CntW'(period_i);
    assign start_evt   = start_i | (periodic_en_i & ~periodic_q);
    assign timeout_hit = (timeout_i != '0) && (cnt_q == timeout_ext - CntW'(1));
    assign period_hit  = (period_i == '0) || (cnt_q == period_ext - CntW'(1));

    // DONE is asynchronous to clk_i: two-flop synchronizer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= sens_done_i;
            done_s    <= done_meta;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_evt) state_d = StRst;
            end
            StRst: begin
                if (cnt_q == RstLast) state_d = StRun;
            end
            StRun: begin
                if (done_s) begin
                    state_d = StCapt;
                end else if (timeout_hit) begin
                    state_d = StDisarm;
                end
            end
            StCapt: begin
                state_d = StDisarm;
            end
            StDisarm: begin
                if (!done_s) begin
                    if (!periodic_en_i) begin
                        state_d = StIdle;
                    end else if (period_i == '0) begin
                        state_d = StRst;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!periodic_en_i) begin
                    state_d = StIdle;
                end else if (period_hit) begin
                    state_d = StRst;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Macro control outputs decoded from state so an async reset drops them at once.
    always_comb begin
        sens_rstn_o = 1'b0;
        sens_en_o   = 1'b0;
        case (state_q)
            StRun, StCapt: begin
                sens_rstn_o = 1'b1;
                sens_en_o   = 1'b1;
            end
            StDisarm: begin
                sens_rstn_o = 1'b1;
            end
            default: begin
                sens_rstn_o = 1'b0;
                sens_en_o   = 1'b0;
            end
        endcase
    end

    // Counter restarts on every state change and saturates otherwise.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    // Datapath: counter, sel latch, result capture and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            periodic_q <= 1'b0;
            sel_q      <= 4'h0;
            result_q   <= 24'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            periodic_q <= periodic_en_i;
            valid_q    <= (state_q == StCapt);
            // sel only changes on entry into RST, never mid-conversion.
            if (state_d == StRst && state_q != StRst) begin
                sel_q <= sel_conv_time_i;
            end
            if (state_q == StIdle && start_evt) begin
                err_q <= 1'b0;
            end else if (state_q == StRun && !done_s && timeout_hit) begin
                err_q <= 1'b1;
            end
            if (state_q == StCapt) begin
                result_q <= sens_dout_i;
                alarm_q  <= (sens_dout_i >= thresh_hi_i);
            end
        end
    end

    assign sens_sel_conv_time_o = sel_q;
    assign result_o             = result_q;
    assign result_valid_o       = valid_q;
    assign busy_o               = (state_q != StIdle);
    assign timeout_err_o        = err_q;
    assign alarm_o              = alarm_q;

endmodule

// File: tb/tb_tempsens_conv_ctrl.sv
// Directed self-checking bench for tempsens_conv_ctrl with a behavioural DONE model.
module tb_tempsens_conv_ctrl;

    localparam int Lim = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        periodic_en;
    logic [23:0] period;
    logic [23:0] timeout;
    logic [3:0]  sel;
    logic [23:0] thresh;
    logic        sens_done;
    logic [23:0] sens_dout;
    logic        sens_rstn;
    logic        sens_en;
    logic [3:0]  sens_sel;
    logic [23:0] result;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    // DONE model knobs
    int done_delay = 50;
    bit done_never = 1'b0;
    int en_cnt;

    tempsens_conv_ctrl #(
        .RstCycles (4),
        .TimeoutW  (24),
        .PeriodW   (24)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .start_i              (start),
        .periodic_en_i        (periodic_en),
        .period_i             (period),
        .timeout_i            (timeout),
        .sel_conv_time_i      (sel),
        .thresh_hi_i          (thresh),
        .sens_done_i          (sens_done),
        .sens_dout_i          (sens_dout),
        .sens_rstn_o          (sens_rstn),
        .sens_en_o            (sens_en),
        .sens_sel_conv_time_o (sens_sel),
        .result_o             (result),
        .result_valid_o       (result_valid),
        .busy_o               (busy),
        .timeout_err_o        (timeout_err),
        .alarm_o              (alarm)
    );

    always #5 clk = ~clk;

    // Macro model: DONE rises done_delay cycles after en, falls once en drops.
    always @(posedge clk) begin
        if (!sens_en) begin
            en_cnt    <= 0;
            sens_done <= 1'b0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (!done_never && en_cnt == done_delay - 1) sens_done <= 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Start a conversion and wait for it to finish.
    task automatic run_conv(input logic [23:0] dout);
        int n;
        sens_dout = dout;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < Lim) begin
            tick();
            n++;
        end
        checks++;
        if (n >= Lim) begin
            errors++;
            $display("FAIL run_conv_done: busy still %0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; periodic_en = 1'b0; period = 24'd0; timeout = 24'd0;
        sel = 4'h0; thresh = 24'hFFFFFF; sens_dout = 24'h0;
        tick();
        tick();
        checks++;
        if ({sens_rstn, sens_en, busy, result_valid, timeout_err, alarm} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {sens_rstn, sens_en, busy, result_valid, timeout_err, alarm});
        end
        checks++;
        if (result !== 24'h0 || sens_sel !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: result %h sel %h expected 000000 0", result, sens_sel);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n, rst_low, valid_cnt;
        logic [3:0] sel_run;
        logic done_at_exit;
        sel = 4'h3; done_delay = 50; done_never = 1'b0; sens_dout = 24'h00ABCD;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; rst_low = 0; valid_cnt = 0; sel_run = 4'h0;
        while (busy && n < Lim) begin
            if (!sens_rstn) rst_low++;
            if (result_valid) valid_cnt++;
            if (sens_en) sel_run = sens_sel;
            tick();
            n++;
        end
        done_at_exit = sens_done;
        checks++;
        if (rst_low !== 4) begin
            errors++;
            $display("FAIL single_rst_low: got %0d cycles expected 4", rst_low);
        end
        checks++;
        if (valid_cnt !== 1) begin
            errors++;
            $display("FAIL single_valid_pulses: got %0d expected 1", valid_cnt);
        end
        checks++;
        if (result !== 24'h00ABCD) begin
            errors++;
            $display("FAIL single_result: got %h expected 00abcd", result);
        end
        checks++;
        if (sel_run !== 4'h3) begin
            errors++;
            $display("FAIL single_sel: got %h expected 3", sel_run);
        end
        checks++;
        if (done_at_exit !== 1'b0 || n >= Lim) begin
            errors++;
            $display("FAIL single_busy_drop: done %b cycles %0d expected done 0", done_at_exit, n);
        end
    endtask

    task automatic test_timeout();
        int n, en_cycles;
        timeout = 24'd100; done_never = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; en_cycles = 0;
        while (busy && n < Lim) begin
            if (sens_en) en_cycles++;
            tick();
            n++;
        end
        checks++;
        if (en_cycles !== 100) begin
            errors++;
            $display("FAIL timeout_run_cycles: got %0d expected 100", en_cycles);
        end
        checks++;
        if (timeout_err !== 1'b1 || sens_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: err %b en %b busy %b expected 1 0 0",
                     timeout_err, sens_en, busy);
        end
        checks++;
        if (result !== 24'h00ABCD) begin
            errors++;
            $display("FAIL timeout_result_kept: got %h expected 00abcd", result);
        end
        timeout = 24'd0; done_never = 1'b0; done_delay = 10;
        sens_dout = 24'h000123;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        n = 0;
        while (busy && n < Lim) begin
            tick();
            n++;
        end
        checks++;
        if (result !== 24'h000123) begin
            errors++;
            $display("FAIL timeout_next_result: got %h expected 000123", result);
        end
    endtask

    task automatic test_periodic();
        int n, gap, idle_seen, valid_cnt, rise;
        period = 24'd10; done_delay = 20; sens_dout = 24'h000456;
        periodic_en = 1'b1;
        tick();
        n = 0;
        while (!result_valid && n < Lim) begin tick(); n++; end
        while (sens_rstn && !sens_en && n < Lim) begin tick(); n++; end
        gap = 0; idle_seen = 0;
        while (!sens_en && n < Lim) begin
            if (!sens_rstn) gap++;
            if (!busy) idle_seen++;
            tick();
            n++;
        end
        checks++;
        if (gap !== 14 || idle_seen !== 0) begin
            errors++;
            $display("FAIL periodic_gap: wait+rst %0d idle %0d expected 14 0", gap, idle_seen);
        end
        // Now in RUN of the second conversion: stop periodic mode.
        periodic_en = 1'b0;
        sens_dout = 24'h000789;
        valid_cnt = 0;
        while (busy && n < Lim) begin
            if (result_valid) valid_cnt++;
            tick();
            n++;
        end
        checks++;
        if (valid_cnt !== 1 || result !== 24'h000789) begin
            errors++;
            $display("FAIL periodic_stop: pulses %0d result %h expected 1 000789",
                     valid_cnt, result);
        end
        rise = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) rise++;
            tick();
        end
        checks++;
        if (rise !== 0) begin
            errors++;
            $display("FAIL periodic_idle: busy cycles %0d expected 0", rise);
        end
        period = 24'd0;
    endtask

    task automatic test_alarm();
        thresh = 24'h001000; done_delay = 8;
        run_conv(24'h000FFF);
        checks++;
        if (alarm !== 1'b0 || result !== 24'h000FFF) begin
            errors++;
            $display("FAIL alarm_below: alarm %b result %h expected 0 000fff", alarm, result);
        end
        run_conv(24'h001000);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_equal: got %b expected 1", alarm);
        end
        run_conv(24'h800001);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_high: got %b expected 1", alarm);
        end
        run_conv(24'h000FFF);
        checks++;
        if (alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_clear: got %b expected 0", alarm);
        end
    endtask

    task automatic test_busy_ignore();
        int n, valid_cnt, rise;
        logic [3:0] sel_mid;
        sel = 4'h5; done_delay = 30; sens_dout = 24'h002000;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!sens_en && n < Lim) begin tick(); n++; end
        tick();
        start = 1'b1;
        sel = 4'hA;
        tick();
        start = 1'b0;
        sel_mid = sens_sel;
        checks++;
        if (sel_mid !== 4'h5) begin
            errors++;
            $display("FAIL busy_sel_hold: got %h expected 5", sel_mid);
        end
        valid_cnt = 0;
        while (busy && n < Lim) begin
            if (result_valid) valid_cnt++;
            tick();
            n++;
        end
        rise = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) rise++;
            tick();
        end
        checks++;
        if (valid_cnt !== 1 || rise !== 0) begin
            errors++;
            $display("FAIL busy_no_queue: pulses %0d later busy %0d expected 1 0",
                     valid_cnt, rise);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (sens_sel !== 4'hA) begin
            errors++;
            $display("FAIL busy_sel_new: got %h expected a", sens_sel);
        end
        n = 0;
        while (busy && n < Lim) begin tick(); n++; end
    endtask

    task automatic test_async_reset();
        int n;
        done_delay = 30;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!sens_en && n < Lim) begin tick(); n++; end
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sens_rstn, sens_en, busy, result_valid, timeout_err, alarm} !== 6'b0) begin
            errors++;
            $display("FAIL async_rst_flags: got %b expected 000000",
                     {sens_rstn, sens_en, busy, result_valid, timeout_err, alarm});
        end
        checks++;
        if (result !== 24'h0 || sens_sel !== 4'h0) begin
            errors++;
            $display("FAIL async_rst_data: result %h sel %h expected 000000 0", result, sens_sel);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sel = 4'h7;
        run_conv(24'h0ABCDE);
        checks++;
        if (result !== 24'h0ABCDE || sens_sel !== 4'h7 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_recover: result %h sel %h alarm %b expected 0abcde 7 1",
                     result, sens_sel, alarm);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_periodic();
        test_alarm();
        test_busy_ignore();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
